mem_bus_arbiter: RTL and testbench

- Shares the single memory bus between two masters: master 0 is the CPU load/store/fetch port, master 1 is a DMA/boot-loader port.
- Each master issues single-cycle request pulses. The arbiter latches them, grants the bus round-robin with one transaction outstanding at a time, and routes the memory completion back to the owning master.
- Includes a watchdog that aborts hung transactions.

---
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between two masters.
//   Master 0 is the CPU port, master 1 the DMA/boot-loader port.
//
//   Each master issues single-cycle request pulses, which are latched into a
//   per-master pending slot. One transaction is outstanding at a time, and
//   grants are round-robin. The memory completion is routed back to the master
//   that owns the bus. A watchdog aborts a WAIT that sees no completion for
//   TIMEOUT_CYCLES cycles.
//
// Ports:
//   i_clk, i_rst_n         clock and synchronous active-low reset
//   i_mX_*                 master X request: data, address, DV pulse, bhw, write_notread
//   o_mX_data, o_mX_DV     master X read data and completion pulse
//   o_mem_*                request to memory; o_mem_DV is a one-cycle strobe
//   i_mem_data, i_mem_DV   completion from memory
//   o_busy                 a transaction is in progress (state != idle)
//   o_timeout              one-cycle pulse when the watchdog aborts a transaction
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_m0_data,
  input  logic [31:0] i_m0_address,
  input  logic        i_m0_DV,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_write_notread,
  output logic [31:0] o_m0_data,
  output logic        o_m0_DV,
  input  logic [31:0] i_m1_data,
  input  logic [31:0] i_m1_address,
  input  logic        i_m1_DV,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_write_notread,
  output logic [31:0] o_m1_data,
  output logic        o_m1_DV,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_mem_address,
  output logic        o_mem_DV,
  output logic [2:0]  o_mem_bhw,
  output logic        o_mem_write_notread,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_DV,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [TIMEOUT_W-1:0] WdLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WdOne  = 1;

  state_e               state_q;
  logic [1:0]           pending_q;
  logic                 last_grant_q;
  logic                 gnt_q;
  logic [TIMEOUT_W-1:0] wd_q;

  logic [31:0] req_data_q [2];
  logic [31:0] req_addr_q [2];
  logic [2:0]  req_bhw_q  [2];
  logic        req_wr_q   [2];

  logic idle_gnt;

  // With both pending the master that did not go last wins; otherwise the
  // only pending master (bit 1 set means master 1).
  always_comb begin
    idle_gnt = pending_q[1];
    if (&pending_q) begin
      idle_gnt = ~last_grant_q;
    end
  end

  assign o_busy = (state_q != StIdle);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q             <= StIdle;
      pending_q           <= '0;
      last_grant_q        <= 1'b1;
      gnt_q               <= 1'b0;
      wd_q                <= '0;
      req_data_q[0]       <= '0;
      req_addr_q[0]       <= '0;
      req_bhw_q[0]        <= '0;
      req_wr_q[0]         <= 1'b0;
      req_data_q[1]       <= '0;
      req_addr_q[1]       <= '0;
      req_bhw_q[1]        <= '0;
      req_wr_q[1]         <= 1'b0;
      o_m0_data           <= '0;
      o_m0_DV             <= 1'b0;
      o_m1_data           <= '0;
      o_m1_DV             <= 1'b0;
      o_mem_data          <= '0;
      o_mem_address       <= '0;
      o_mem_DV            <= 1'b0;
      o_mem_bhw           <= '0;
      o_mem_write_notread <= 1'b0;
      o_timeout           <= 1'b0;
    end else begin
      o_m0_DV   <= 1'b0;
      o_m1_DV   <= 1'b0;
      o_timeout <= 1'b0;

      // A pulse is only taken into an empty slot; repeats while pending are dropped.
      if (i_m0_DV && !pending_q[0]) begin
        pending_q[0]  <= 1'b1;
        req_data_q[0] <= i_m0_data;
        req_addr_q[0] <= i_m0_address;
        req_bhw_q[0]  <= i_m0_bhw;
        req_wr_q[0]   <= i_m0_write_notread;
      end
      if (i_m1_DV && !pending_q[1]) begin
        pending_q[1]  <= 1'b1;
        req_data_q[1] <= i_m1_data;
        req_addr_q[1] <= i_m1_address;
        req_bhw_q[1]  <= i_m1_bhw;
        req_wr_q[1]   <= i_m1_write_notread;
      end

      case (state_q)
        StIdle: begin
          if (|pending_q) begin
            gnt_q               <= idle_gnt;
            o_mem_DV            <= 1'b1;
            o_mem_data          <= req_data_q[idle_gnt];
            o_mem_address       <= req_addr_q[idle_gnt];
            o_mem_bhw           <= req_bhw_q[idle_gnt];
            o_mem_write_notread <= req_wr_q[idle_gnt];
            state_q             <= StIssue;
          end
        end
        StIssue: begin
          o_mem_DV <= 1'b0;
          wd_q     <= '0;
          state_q  <= StWait;
        end
        StWait: begin
          // Completion beats a coinciding timeout.
          if (i_mem_DV || (wd_q == WdLast)) begin
            if (gnt_q) begin
              o_m1_DV   <= 1'b1;
              o_m1_data <= i_mem_DV ? i_mem_data : 32'h0;
            end else begin
              o_m0_DV   <= 1'b1;
              o_m0_data <= i_mem_DV ? i_mem_data : 32'h0;
            end
            o_timeout           <= ~i_mem_DV;
            pending_q[gnt_q]    <= 1'b0;
            last_grant_q        <= gnt_q;
            o_mem_data          <= '0;
            o_mem_address       <= '0;
            o_mem_bhw           <= '0;
            o_mem_write_notread <= 1'b0;
            state_q             <= StIdle;
          end else begin
            wd_q <= wd_q + WdOne;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// model of the bus (owner + cycles since grant).
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_wdata, m0_addr, m1_wdata, m1_addr;
  logic        m0_dv, m1_dv, m0_wr, m1_wr;
  logic [2:0]  m0_bhw, m1_bhw;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic        mem_strobe, mem_wr, mem_dv;
  logic [2:0]  mem_bhw;
  logic        busy, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (8)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_m0_data          (m0_wdata),
    .i_m0_address       (m0_addr),
    .i_m0_DV            (m0_dv),
    .i_m0_bhw           (m0_bhw),
    .i_m0_write_notread (m0_wr),
    .o_m0_data          (m0_rdata),
    .o_m0_DV            (m0_done),
    .i_m1_data          (m1_wdata),
    .i_m1_address       (m1_addr),
    .i_m1_DV            (m1_dv),
    .i_m1_bhw           (m1_bhw),
    .i_m1_write_notread (m1_wr),
    .o_m1_data          (m1_rdata),
    .o_m1_DV            (m1_done),
    .o_mem_data         (mem_wdata),
    .o_mem_address      (mem_addr),
    .o_mem_DV           (mem_strobe),
    .o_mem_bhw          (mem_bhw),
    .o_mem_write_notread(mem_wr),
    .i_mem_data         (mem_rdata),
    .i_mem_DV           (mem_dv),
    .o_busy             (busy),
    .o_timeout          (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // own = master holding the bus (-1 none); age = cycles since the grant
  // (0 is the strobe cycle, 1..TO are wait cycles).
  logic        mp [2];
  logic [31:0] fa [2];
  logic [31:0] fd [2];
  logic [2:0]  fb [2];
  logic        fw [2];
  logic [31:0] e_data [2];
  logic        e_dv [2];
  logic        e_to;
  int          own, age, last;
  logic        pre0, pre1;

  always @(posedge clk) begin
    if (!rst_n) begin
      own = -1; age = 0; last = 1; e_to = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mp[i] = 1'b0; fa[i] = '0; fd[i] = '0; fb[i] = '0; fw[i] = 1'b0;
        e_data[i] = '0; e_dv[i] = 1'b0;
      end
    end else begin
      pre0 = mp[0];
      pre1 = mp[1];
      e_dv[0] = 1'b0; e_dv[1] = 1'b0; e_to = 1'b0;
      if (m0_dv && !mp[0]) begin
        mp[0] = 1'b1; fa[0] = m0_addr; fd[0] = m0_wdata; fb[0] = m0_bhw; fw[0] = m0_wr;
      end
      if (m1_dv && !mp[1]) begin
        mp[1] = 1'b1; fa[1] = m1_addr; fd[1] = m1_wdata; fb[1] = m1_bhw; fw[1] = m1_wr;
      end
      if (own < 0) begin
        if (pre0 || pre1) begin
          own = (pre0 && pre1) ? 1 - last : (pre0 ? 0 : 1);
          age = 0;
        end
      end else if (age == 0) begin
        age = 1;
      end else if (mem_dv || age == TO) begin
        e_dv[own]   = 1'b1;
        e_data[own] = mem_dv ? mem_rdata : 32'h0;
        e_to        = !mem_dv;
        mp[own]     = 1'b0;
        last        = own;
        own         = -1;
      end else begin
        age++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] ea, ed;
  logic [2:0]  eb;
  logic        ew;

  always @(negedge clk) begin
    if (chk_en) begin
      if (own >= 0) begin
        ea = fa[own]; ed = fd[own]; eb = fb[own]; ew = fw[own];
      end else begin
        ea = '0; ed = '0; eb = '0; ew = 1'b0;
      end
      chk("busy", busy, own >= 0);
      chk("mem_dv", mem_strobe, (own >= 0) && (age == 0));
      chk("mem_addr", mem_addr, ea);
      chk("mem_data", mem_wdata, ed);
      chk("mem_bhw", mem_bhw, eb);
      chk("mem_wr", mem_wr, ew);
      chk("m0_dv", m0_done, e_dv[0]);
      chk("m0_data", m0_rdata, e_data[0]);
      chk("m1_dv", m1_done, e_dv[1]);
      chk("m1_data", m1_rdata, e_data[1]);
      chk("timeout", timeout, e_to);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    m0_dv  = 1'b0;
    m1_dv  = 1'b0;
    mem_dv = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_dv", mem_strobe, 0);
    chk("rst_m0_dv", m0_done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_m0_data", m0_rdata, 0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] b, input logic w);
    if (m == 0) begin
      m0_dv = 1'b1; m0_addr = a; m0_wdata = d; m0_bhw = b; m0_wr = w;
    end else begin
      m1_dv = 1'b1; m1_addr = a; m1_wdata = d; m1_bhw = b; m1_wr = w;
    end
  endtask

  task automatic mem_reply(input logic [31:0] d);
    mem_dv = 1'b1;
    mem_rdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_dv = 1'b0; m1_dv = 1'b0; mem_dv = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_bhw = '0; m0_wr = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_bhw = '0; m1_wr = 1'b0;
    mem_rdata = '0;

    // 1: single read, latency
    do_reset();
    req(0, 32'h100, 32'h0, 3'b010, 1'b0);                 // c0
    cycles(2);                                            // c2
    @(negedge clk);
    chk("s1_strobe", mem_strobe, 1);
    chk("s1_addr", mem_addr, 32'h100);
    chk("s1_bhw", mem_bhw, 3'b010);
    cycles(2);                                            // c4
    mem_reply(32'hDEADBEEF);
    next_cycle();                                         // c5
    @(negedge clk);
    chk("s1_m0_dv", m0_done, 1);
    chk("s1_m0_data", m0_rdata, 32'hDEADBEEF);
    chk("s1_busy", busy, 0);

    // 2: simultaneous requests, alternation
    do_reset();
    req(0, 32'h200, 32'h0, 3'b100, 1'b0);                 // c0
    req(1, 32'h300, 32'h0, 3'b100, 1'b0);
    cycles(2);                                            // c2
    @(negedge clk);
    chk("s2_first_addr", mem_addr, 32'h200);
    cycles(2);                                            // c4
    mem_reply(32'h11111111);
    next_cycle();                                         // c5
    req(0, 32'h204, 32'h0, 3'b100, 1'b0);
    @(negedge clk);
    chk("s2_m0_dv", m0_done, 1);
    next_cycle();                                         // c6
    @(negedge clk);
    chk("s2_m1_strobe", mem_strobe, 1);
    chk("s2_m1_addr", mem_addr, 32'h300);
    next_cycle();                                         // c7
    mem_reply(32'h22222222);
    next_cycle();                                         // c8
    req(1, 32'h304, 32'h0, 3'b100, 1'b0);
    @(negedge clk);
    chk("s2_m1_data", m1_rdata, 32'h22222222);
    next_cycle();                                         // c9
    @(negedge clk);
    chk("s2_third_addr", mem_addr, 32'h204);
    next_cycle();                                         // c10
    mem_reply(32'h33333333);
    cycles(2);                                            // c12
    @(negedge clk);
    chk("s2_fourth_addr", mem_addr, 32'h304);
    next_cycle();                                         // c13
    mem_reply(32'h44444444);
    cycles(2);

    // 3: master 1 write
    next_cycle();                                         // c0
    req(1, 32'h2000, 32'h55, 3'b100, 1'b1);
    cycles(2);                                            // c2
    @(negedge clk);
    chk("s3_wr", mem_wr, 1);
    chk("s3_data", mem_wdata, 32'h55);
    chk("s3_addr", mem_addr, 32'h2000);
    chk("s3_m0_dv_a", m0_done, 0);
    next_cycle();                                         // c3
    @(negedge clk);
    chk("s3_wr_hold", mem_wr, 1);
    chk("s3_data_hold", mem_wdata, 32'h55);
    chk("s3_strobe_low", mem_strobe, 0);
    next_cycle();                                         // c4
    mem_reply(32'h77);
    next_cycle();                                         // c5
    @(negedge clk);
    chk("s3_m1_dv", m1_done, 1);
    chk("s3_m0_dv_b", m0_done, 0);

    // 4: watchdog abort, queued master 1 follows
    next_cycle();                                         // c0
    req(0, 32'h400, 32'h0, 3'b010, 1'b0);
    next_cycle();                                         // c1
    req(1, 32'h404, 32'h0, 3'b010, 1'b0);
    next_cycle();                                         // c2
    @(negedge clk);
    chk("s4_addr", mem_addr, 32'h400);
    cycles(4);                                            // c6
    @(negedge clk);
    chk("s4_no_early_to", timeout, 0);
    chk("s4_busy", busy, 1);
    next_cycle();                                         // c7
    @(negedge clk);
    chk("s4_timeout", timeout, 1);
    chk("s4_m0_dv", m0_done, 1);
    chk("s4_m0_data", m0_rdata, 0);
    next_cycle();                                         // c8
    @(negedge clk);
    chk("s4_m1_strobe", mem_strobe, 1);
    chk("s4_m1_addr", mem_addr, 32'h404);
    next_cycle();                                         // c9
    mem_reply(32'h3333);
    next_cycle();                                         // c10
    @(negedge clk);
    chk("s4_m1_data", m1_rdata, 32'h3333);

    // 5: repeat pulse while pending, spurious memory completion
    next_cycle();                                         // c0
    req(0, 32'h500, 32'h0, 3'b001, 1'b0);
    next_cycle();                                         // c1
    req(0, 32'h600, 32'h0, 3'b001, 1'b0);
    next_cycle();                                         // c2
    @(negedge clk);
    chk("s5_addr", mem_addr, 32'h500);
    next_cycle();                                         // c3
    mem_reply(32'h4444);
    next_cycle();                                         // c4
    next_cycle();                                         // c5
    mem_reply(32'h5555);
    @(negedge clk);
    chk("s5_idle", busy, 0);
    chk("s5_idle_addr", mem_addr, 0);
    next_cycle();                                         // c6
    @(negedge clk);
    chk("s5_spur_m0", m0_done, 0);
    chk("s5_spur_m1", m1_done, 0);
    chk("s5_hold", m0_rdata, 32'h4444);

    // 6: reset during wait
    next_cycle();                                         // c0
    req(0, 32'h700, 32'h0, 3'b010, 1'b0);
    cycles(3);                                            // c3
    rst_n = 1'b0;
    next_cycle();                                         // c4
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_busy", busy, 0);
    next_cycle();                                         // c5
    mem_reply(32'h6666);
    next_cycle();                                         // c6
    @(negedge clk);
    chk("s6_no_m0_dv", m0_done, 0);
    chk("s6_busy2", busy, 0);
    next_cycle();                                         // c7
    req(1, 32'h800, 32'h0, 3'b010, 1'b0);
    cycles(2);                                            // c9
    @(negedge clk);
    chk("s6_m1_addr", mem_addr, 32'h800);
    next_cycle();                                         // c10
    mem_reply(32'h7777);
    next_cycle();                                         // c11
    @(negedge clk);
    chk("s6_m1_data", m1_rdata, 32'h7777);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) req(0, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) req(1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) mem_reply($urandom);
    end
    next_cycle();
    rst_n = 1'b1;
    cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
